power_seq_ctrl: RTL and testbench

Parametrised power-gating sequencer for NUM_DOM independently switchable domains. Each domain gets the same isolation, retention and power-switch sequencing as the single-domain power controller. It adds programmable per-step dwell times and per-domain status. A single-switch token ensures only one domain is in a power transition at a time, which limits rush current. It sits beside the gated datapath blocks (e.g. MSB_RCA) and drives their iso_en / ret_en / pse inputs.

---
 rtl/power_seq_ctrl_if.sv | 22 ++
 rtl/power_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_power_seq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/power_seq_ctrl_if.sv
// Bundles the per-domain request and sequencing outputs of power_seq_ctrl.
// master = the sequencer, slave = whoever drives requests and watches status.
interface power_seq_ctrl_if #(
    parameter int NUM_DOM = 2
);
    logic [NUM_DOM-1:0] p;
    logic [NUM_DOM-1:0] iso_en;
    logic [NUM_DOM-1:0] ret_en;
    logic [NUM_DOM-1:0] pse;
    logic [NUM_DOM-1:0] pwr_ok;
    logic               busy;

    modport master (
        input  p,
        output iso_en, ret_en, pse, pwr_ok, busy
    );

    modport slave (
        output p,
        input  iso_en, ret_en, pse, pwr_ok, busy
    );
endinterface

// File: rtl/power_seq_ctrl.sv
// Multi-domain power-gating sequencer: one iso/ret/pse FSM per domain, a single
// shared transition token so only one domain switches at a time.
module power_seq_dom #(
    parameter int ISO_CYC = 2,
    parameter int RET_CYC = 2,
    parameter int PSW_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic p,
    input  logic grant,
    output logic pending,
    output logic trans_d,
    output logic iso_en,
    output logic ret_en,
    output logic pse,
    output logic pwr_ok
);
    typedef enum logic [2:0] {
        ST_ON, ST_ISO, ST_RET, ST_OFF, ST_PWRUP, ST_RESTORE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iso_q, iso_d, ret_q, ret_d, pse_q, pse_d, ok_q, ok_d;
    logic             last;

    assign last    = (cnt_q == CNT_ONE);
    assign pending = ((state_q == ST_ON) && p) || ((state_q == ST_OFF) && !p);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Counter is loaded on entry; the step ends on the edge where it reads 1.
        case (state_q)
            ST_ON: if (grant) begin
                state_d = ST_ISO;
                cnt_d   = CNT_W'(ISO_CYC);
            end
            ST_ISO: if (last) begin
                state_d = ST_RET;
                cnt_d   = CNT_W'(RET_CYC);
            end else cnt_d = cnt_q - CNT_ONE;
            ST_RET: if (last) begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end else cnt_d = cnt_q - CNT_ONE;
            ST_OFF: if (grant) begin
                state_d = ST_PWRUP;
                cnt_d   = CNT_W'(PSW_CYC);
            end
            ST_PWRUP: if (last) begin
                state_d = ST_RESTORE;
                cnt_d   = CNT_W'(ISO_CYC);
            end else cnt_d = cnt_q - CNT_ONE;
            ST_RESTORE: if (last) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end else cnt_d = cnt_q - CNT_ONE;
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they flip on the same edge.
        iso_d = 1'b0;
        ret_d = 1'b0;
        pse_d = 1'b1;
        ok_d  = 1'b0;
        case (state_d)
            ST_ON:                 ok_d  = 1'b1;
            ST_ISO, ST_RESTORE:    iso_d = 1'b1;
            ST_RET, ST_PWRUP: begin
                iso_d = 1'b1;
                ret_d = 1'b1;
            end
            ST_OFF: begin
                iso_d = 1'b1;
                ret_d = 1'b1;
                pse_d = 1'b0;
            end
            default:               ok_d  = 1'b1;
        endcase
        trans_d = (state_d == ST_ISO) || (state_d == ST_RET) ||
                  (state_d == ST_PWRUP) || (state_d == ST_RESTORE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            iso_q   <= 1'b0;
            ret_q   <= 1'b0;
            pse_q   <= 1'b1;
            ok_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iso_q   <= iso_d;
            ret_q   <= ret_d;
            pse_q   <= pse_d;
            ok_q    <= ok_d;
        end
    end

    assign iso_en = iso_q;
    assign ret_en = ret_q;
    assign pse    = pse_q;
    assign pwr_ok = ok_q;
endmodule

module power_seq_ctrl #(
    parameter int NUM_DOM = 2,
    parameter int ISO_CYC = 2,
    parameter int RET_CYC = 2,
    parameter int PSW_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    power_seq_ctrl_if.master      bus
);
    logic [NUM_DOM-1:0] pending, grant, trans_d;
    logic               busy_q, busy_d, found;

    // Fixed priority, and only while no domain holds the token.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (pending[i] && !found) begin
                grant[i] = !busy_q;
                found    = 1'b1;
            end
        end
    end

    assign busy_d = |trans_d;

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end

    assign bus.busy = busy_q;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
        power_seq_dom #(
            .ISO_CYC(ISO_CYC),
            .RET_CYC(RET_CYC),
            .PSW_CYC(PSW_CYC),
            .CNT_W  (CNT_W)
        ) u_dom (
            .clk    (clk),
            .rst    (rst),
            .p      (bus.p[g]),
            .grant  (grant[g]),
            .pending(pending[g]),
            .trans_d(trans_d[g]),
            .iso_en (bus.iso_en[g]),
            .ret_en (bus.ret_en[g]),
            .pse    (bus.pse[g]),
            .pwr_ok (bus.pwr_ok[g])
        );
    end
endmodule

// File: tb/tb_power_seq_ctrl.sv
// Bench for power_seq_ctrl: hand-derived vector table, directed corner cases and
// a long random run, all checked against a timeline-based model every cycle.
module tb_power_seq_ctrl;
    localparam int ND  = 4;
    localparam int ISO = 2;
    localparam int RET = 1;
    localparam int PSW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    power_seq_ctrl_if #(.NUM_DOM(ND)) bus ();

    power_seq_ctrl #(
        .NUM_DOM(ND), .ISO_CYC(ISO), .RET_CYC(RET), .PSW_CYC(PSW), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          rst;
        logic [ND-1:0] p;
        logic [ND-1:0] iso, ret, pse, ok;
        logic          busy;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;
    int t = 0;

    // Model: a domain is either idle (ON/OFF) or running a sequence started at m_st.
    bit m_act [ND];
    bit m_off [ND];
    bit m_dir [ND];  // 1 = powering down
    int m_st  [ND];
    logic [ND-1:0] e_iso, e_ret, e_pse, e_ok;
    logic          e_busy;
    logic [ND-1:0] prev_pse = '1, prev_ret = '0;

    task automatic model_edge(input logic r, input logic [ND-1:0] pv);
        int g;
        bit bsy;
        t++;
        if (r) begin
            for (int i = 0; i < ND; i++) begin
                m_act[i] = 0;
                m_off[i] = 0;
            end
            return;
        end
        bsy = 0;
        g   = -1;
        for (int i = 0; i < ND; i++) if (m_act[i]) bsy = 1;
        for (int i = 0; i < ND; i++)
            if (g < 0 && !m_act[i] && (m_off[i] ? !pv[i] : pv[i])) g = i;
        for (int i = 0; i < ND; i++)
            if (m_act[i] && (t - m_st[i]) == (m_dir[i] ? ISO + RET : PSW + ISO)) begin
                m_act[i] = 0;
                m_off[i] = m_dir[i];
            end
        if (!bsy && g >= 0) begin
            m_act[g] = 1;
            m_st[g]  = t;
            m_dir[g] = !m_off[g];
        end
    endtask

    task automatic model_outputs();
        int e;
        e_busy = 1'b0;
        for (int i = 0; i < ND; i++) begin
            e = t - m_st[i];
            if (!m_act[i]) begin
                e_iso[i] = m_off[i];
                e_ret[i] = m_off[i];
                e_pse[i] = !m_off[i];
                e_ok[i]  = !m_off[i];
            end else begin
                e_busy   = 1'b1;
                e_iso[i] = 1'b1;
                e_pse[i] = 1'b1;
                e_ok[i]  = 1'b0;
                e_ret[i] = m_dir[i] ? (e >= ISO) : (e < PSW);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [ND-1:0] trans;
        model_outputs();
        vectors++;
        if (bus.iso_en !== e_iso || bus.ret_en !== e_ret || bus.pse !== e_pse ||
            bus.pwr_ok !== e_ok || bus.busy !== e_busy) begin
            miscompares++;
            $display("FAIL model t=%0d iso %b/%b ret %b/%b pse %b/%b ok %b/%b busy %b/%b (got/want)",
                     t, bus.iso_en, e_iso, bus.ret_en, e_ret, bus.pse, e_pse,
                     bus.pwr_ok, e_ok, bus.busy, e_busy);
        end
        trans = ~bus.pwr_ok & bus.pse;
        for (int i = 0; i < ND; i++) begin
            if (!bus.iso_en[i] && (!bus.pse[i] || bus.ret_en[i])) begin
                miscompares++;
                $display("FAIL inv_iso t=%0d dom %0d", t, i);
            end
            if (prev_pse[i] && !bus.pse[i] && !bus.ret_en[i]) begin
                miscompares++;
                $display("FAIL inv_pse_fall t=%0d dom %0d", t, i);
            end
            if (prev_ret[i] && !bus.ret_en[i] && !bus.pse[i]) begin
                miscompares++;
                $display("FAIL inv_ret_fall t=%0d dom %0d", t, i);
            end
        end
        if (!$onehot0(trans)) begin
            miscompares++;
            $display("FAIL inv_onehot t=%0d trans %b want onehot0", t, trans);
        end
        prev_pse = bus.pse;
        prev_ret = bus.ret_en;
    endtask

    task automatic tick(input logic r, input logic [ND-1:0] pv);
        rst   = r;
        bus.p = pv;
        @(posedge clk);
        model_edge(r, pv);
        @(negedge clk);
        check_cycle();
    endtask

    vec_t tbl [12];
    logic [ND-1:0] pv;

    initial begin
        rst   = 1'b1;
        bus.p = '0;
        // Single domain 0 with ISO=2 RET=1 PSW=3: down then up.
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0};
        tbl[1]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'hF, 4'hE, 1'b1};
        tbl[2]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'hF, 4'hE, 1'b1};
        tbl[3]  = '{1'b0, 4'h1, 4'h1, 4'h1, 4'hF, 4'hE, 1'b1};
        tbl[4]  = '{1'b0, 4'h1, 4'h1, 4'h1, 4'hE, 4'hE, 1'b0};
        tbl[5]  = '{1'b0, 4'h1, 4'h1, 4'h1, 4'hE, 4'hE, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 4'h1, 4'h1, 4'hF, 4'hE, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 4'h1, 4'h1, 4'hF, 4'hE, 1'b1};
        tbl[8]  = '{1'b0, 4'h0, 4'h1, 4'h1, 4'hF, 4'hE, 1'b1};
        tbl[9]  = '{1'b0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hE, 1'b1};
        tbl[10] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hE, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0};

        @(negedge clk);
        for (int r = 0; r < 12; r++) begin
            tick(tbl[r].rst, tbl[r].p);
            chk($sformatf("table_row%0d", r),
                {15'd0, bus.iso_en, bus.ret_en, bus.pse, bus.pwr_ok, bus.busy},
                {15'd0, tbl[r].iso, tbl[r].ret, tbl[r].pse, tbl[r].ok, tbl[r].busy});
        end

        // Contention: domains 0 and 2 request together; 2 waits one cycle after 0 is OFF.
        tick(1'b0, 4'b0101);
        for (int n = 0; n < 20 && bus.pse[0] !== 1'b0; n++) tick(1'b0, 4'b0101);
        chk("contend_dom0_off", {31'd0, bus.pse[0]}, 32'd0);
        chk("contend_gap_busy", {31'd0, bus.busy}, 32'd0);
        tick(1'b0, 4'b0101);
        chk("contend_dom2_iso", {30'd0, bus.iso_en[2], bus.iso_en[1]}, 32'd2);
        for (int n = 0; n < 8; n++) tick(1'b0, 4'b0101);
        for (int n = 0; n < 20; n++) tick(1'b0, 4'b0000);
        chk("contend_all_on", {28'd0, bus.pwr_ok}, 32'hF);

        // Drop p[0] while domain 0 is in RET: sequence still completes.
        tick(1'b0, 4'b0001);
        tick(1'b0, 4'b0001);
        tick(1'b0, 4'b0001);
        chk("toggle_in_ret", {30'd0, bus.ret_en[0], bus.pse[0]}, 32'd3);
        tick(1'b0, 4'b0000);
        chk("toggle_reaches_off", {31'd0, bus.pse[0]}, 32'd0);
        for (int n = 0; n < 8; n++) tick(1'b0, 4'b0000);
        chk("toggle_back_on", {31'd0, bus.pwr_ok[0]}, 32'd1);

        // Reset while domain 0 is in RET and domain 1 is pending.
        tick(1'b0, 4'b0011);
        tick(1'b0, 4'b0011);
        tick(1'b0, 4'b0011);
        chk("pre_reset_ret", {31'd0, bus.ret_en[0]}, 32'd1);
        tick(1'b1, 4'b0011);
        chk("reset_outputs",
            {15'd0, bus.iso_en, bus.ret_en, bus.pse, bus.pwr_ok, bus.busy},
            {15'd0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0});
        tick(1'b0, 4'b0000);
        chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);

        // Random sweep: slowly changing requests, rare resets.
        pv = '0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(7) == 0) pv[$urandom_range(ND - 1)] ^= 1'b1;
            tick(($urandom_range(599) == 0), pv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
